fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 13 +
 rtl/programCounter.sv | 12 +
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: PC width and FSM state encoding.
package fetch_sequencer_pkg;

  localparam int PC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/programCounter.sv
// PC incrementer: returns PC + 1, wrapping modulo 2**W with no carry out.
module programCounter #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_pc,
  output logic [W-1:0] o_pc_inc
);

  // Plain W-bit add; the carry is dropped so FF wraps to 00.
  assign o_pc_inc = i_pc + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests a word at PC, holds it for decode,
// then advances. Supports halt (after the current instruction) and redirect.
//
// Handshakes: imem side completes in the cycle imem_req && imem_ready;
// decode side transfers in the cycle ins_valid && ins_ready. ins_valid and
// imem_req depend only on state, never combinationally on any input.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int              IW       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [IW-1:0]   imem_rdata,
  output logic            ins_valid,
  output logic [IW-1:0]   ins_data,
  output logic [PC_W-1:0] ins_pc,
  input  logic            ins_ready,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_halt_pending;
  logic [IW-1:0]   r_ins_data;
  logic [PC_W-1:0] r_ins_pc;

  state_t          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_halt_pending_nxt;
  logic            w_capture;

  programCounter #(.W(PC_W)) u_pc_inc (
    .i_pc     (r_pc),
    .o_pc_inc (w_pc_inc)
  );

  // Next-state, next-PC and halt bookkeeping; redirect outranks memory and decode.
  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_halt_pending_nxt = r_halt_pending;
    w_capture          = 1'b0;

    if (halt && (r_state == ST_FETCH || r_state == ST_HOLD))
      w_halt_pending_nxt = 1'b1;

    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (redirect_valid)
          w_pc_nxt = redirect_pc;
        if (start) begin
          w_state_nxt        = ST_FETCH;
          w_halt_pending_nxt = 1'b0;
        end
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end else if (imem_ready) begin
          w_capture   = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_FETCH;
        end else if (ins_ready) begin
          // A halt arriving in the same cycle as the transfer still counts.
          w_state_nxt = (r_halt_pending || halt) ? ST_HALTED : ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_pc           <= RESET_PC;
      r_halt_pending <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_halt_pending <= w_halt_pending_nxt;
    end
  end

  // Instruction hold register, loaded only when a fetch completes undisturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins_data <= '0;
      r_ins_pc   <= '0;
    end else if (w_capture) begin
      r_ins_data <= imem_rdata;
      r_ins_pc   <= r_pc;
    end
  end

  assign imem_req  = (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign ins_valid = (r_state == ST_HOLD);
  assign ins_data  = r_ins_data;
  assign ins_pc    = r_ins_pc;
  assign busy      = (r_state == ST_FETCH) || (r_state == ST_HOLD);
  assign dbg_state = r_state;

endmodule
